// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequential digit-serial multiplier controller.
// Holds the FSM state encoding and the digit geometry used by core and controller.
package mul_seq_ctrl_pkg;

    localparam int DIGIT_W = 2;
    localparam int PP_W    = 2 * DIGIT_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul2x2_core.sv
// Combinational 2-bit x 2-bit unsigned digit multiplier.
// Built from four AND partial products reduced with half-adder style XOR/AND stages.
module mul2x2_core
    import mul_seq_ctrl_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic [PP_W-1:0]    p
);

    logic pp00;
    logic pp10;
    logic pp01;
    logic pp11;
    logic carry1;
    logic carry2;

    always_comb begin
        pp00   = x[0] & y[0];
        pp10   = x[1] & y[0];
        pp01   = x[0] & y[1];
        pp11   = x[1] & y[1];
        // Column 1 sums the two cross terms; its carry feeds column 2.
        carry1 = pp10 & pp01;
        carry2 = pp11 & carry1;
        p[0]   = pp00;
        p[1]   = pp10 ^ pp01;
        p[2]   = pp11 ^ carry1;
        p[3]   = carry2;
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier that time-shares one 2x2 digit core,
// accumulating one shifted digit-pair product per cycle behind valid/ready handshakes.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int N  = WIDTH / DIGIT_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e          state_q;
    state_e          state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] b_d;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_d;
    logic [CW-1:0]    i_q;
    logic [CW-1:0]    i_d;
    logic [CW-1:0]    j_q;
    logic [CW-1:0]    j_d;

    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [PP_W-1:0]    pp4;
    logic [CW:0]        pos;
    logic [PW-1:0]      pp_shifted;

    // Digit i of a and digit j of b select the current pair for the shared core.
    assign a_dig = a_q[{i_q, 1'b0} +: DIGIT_W];
    assign b_dig = b_q[{j_q, 1'b0} +: DIGIT_W];

    mul2x2_core u_core (
        .x (a_dig),
        .y (b_dig),
        .p (pp4)
    );

    assign pos        = {1'b0, i_q} + {1'b0, j_q};
    assign pp_shifted = PW'(pp4) << {pos, 1'b0};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + pp_shifted;
                // j is the inner loop; the run ends after pair (N-1, N-1), no early-out.
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        i_d = i_q + CW'(1);
                    end
                end else begin
                    j_d = j_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign product   = acc_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: table-driven products through a scoreboard,
// plus hand-written timing, backpressure, reset and back-to-back sequences.
module tb_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    logic        w2_in_valid;
    logic        w2_in_ready;
    logic [1:0]  w2_a;
    logic [1:0]  w2_b;
    logic        w2_out_valid;
    logic        w2_out_ready;
    logic [3:0]  w2_product;
    logic        w2_busy;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          accept_cnt = 0;
    int          accept_edge = 0;
    int          done_cnt = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_v;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    mul_seq_ctrl #(.WIDTH(2)) dut_w2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w2_in_valid),
        .in_ready  (w2_in_ready),
        .a         (w2_a),
        .b         (w2_b),
        .out_valid (w2_out_valid),
        .out_ready (w2_out_ready),
        .product   (w2_product),
        .busy      (w2_busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic boundExpired(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: timed out, expected event did not occur", name);
    endtask

    // Monitor samples at the negedge, so handshakes seen here complete on the next posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                accept_cnt++;
                accept_edge = cyc + 1;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    boundExpired("unexpected_output");
                end else begin
                    exp_v = sb.pop_front();
                    checkOutput("product", 32'(product), 32'(exp_v));
                    done_cnt++;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] ev);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) boundExpired("wait_in_ready");
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        sb.push_back(ev);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitOutValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) boundExpired("wait_out_valid");
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) boundExpired("drain");
    endtask

    task automatic waitAccept(input int c0);
        int n = 0;
        while (accept_cnt == c0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (accept_cnt == c0) boundExpired("wait_accept");
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int busy_cnt;
        int n;
        int e1;
        int e2;
        int d0;

        vecs[0] = '{a: 8'd255, b: 8'd255, exp: 16'd65025};
        vecs[1] = '{a: 8'd0,   b: 8'd173, exp: 16'd0};
        vecs[2] = '{a: 8'd1,   b: 8'd1,   exp: 16'd1};
        vecs[3] = '{a: 8'd128, b: 8'd2,   exp: 16'd256};
        vecs[4] = '{a: 8'd15,  b: 8'd17,  exp: 16'd255};
        vecs[5] = '{a: 8'd100, b: 8'd100, exp: 16'd10000};
        vecs[6] = '{a: 8'd170, b: 8'd85,  exp: 16'd14450};
        vecs[7] = '{a: 8'd255, b: 8'd1,   exp: 16'd255};

        rst          = 1'b1;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        out_ready    = 1'b1;
        w2_in_valid  = 1'b0;
        w2_a         = '0;
        w2_b         = '0;
        w2_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_product", 32'(product), 32'd0);
        checkOutput("reset_w2_in_ready", 32'(w2_in_ready), 32'd1);

        for (int k = 0; k < 8; k++) begin
            applyStimulus(vecs[k].a, vecs[k].b, vecs[k].exp);
            waitDrain();
        end

        $display("[TB] 255x255 latency and return to idle");
        applyStimulus(8'd255, 8'd255, 16'd65025);
        waitOutValid(lat);
        checkOutput("latency_255", 32'(lat), 32'd16);
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_consume", 32'(in_ready), 32'd1);
        checkOutput("out_valid_after_consume", 32'(out_valid), 32'd0);
        waitDrain();

        $display("[TB] zero operand, no early-out");
        applyStimulus(8'd0, 8'd173, 16'd0);
        busy_cnt = 0;
        n = 0;
        while (busy && n < 50) begin
            busy_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("busy_cycles_zero", 32'(busy_cnt), 32'd17);
        waitDrain();

        $display("[TB] backpressure in DONE");
        out_ready = 1'b0;
        applyStimulus(8'd200, 8'd3, 16'd600);
        waitOutValid(lat);
        checkOutput("latency_200x3", 32'(lat), 32'd16);
        for (int k = 0; k < 10; k++) begin
            checkOutput("held_product", 32'(product), 32'd600);
            checkOutput("held_out_valid", 32'(out_valid), 32'd1);
            checkOutput("held_in_ready", 32'(in_ready), 32'd0);
            in_valid = k[0];
            a        = 8'(k + 1);
            b        = 8'(k + 7);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        d0        = done_cnt;
        @(posedge clk);
        #1;
        checkOutput("backpressure_released", 32'(done_cnt), 32'(d0 + 1));
        checkOutput("idle_after_release", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_spurious_accept", 32'(busy), 32'd0);

        $display("[TB] reset during RUN");
        applyStimulus(8'd77, 8'd91, 16'd7007);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_product", 32'(product), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        applyStimulus(8'd77, 8'd91, 16'd7007);
        waitDrain();

        $display("[TB] back-to-back acceptance");
        d0       = accept_cnt;
        a        = 8'd12;
        b        = 8'd34;
        in_valid = 1'b1;
        sb.push_back(16'd408);
        waitAccept(d0);
        e1       = accept_edge;
        a        = 8'd250;
        b        = 8'd251;
        sb.push_back(16'd62750);
        waitAccept(d0 + 1);
        e2       = accept_edge;
        in_valid = 1'b0;
        checkOutput("issue_interval", 32'(e2 - e1), 32'd18);
        waitDrain();

        $display("[TB] WIDTH=2 exhaustive");
        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                w2_a        = 2'(ai);
                w2_b        = 2'(bi);
                w2_in_valid = 1'b1;
                @(posedge clk);
                #1;
                w2_in_valid = 1'b0;
                checkOutput("w2_busy", 32'(w2_busy), 32'd1);
                @(posedge clk);
                #1;
                checkOutput("w2_out_valid", 32'(w2_out_valid), 32'd1);
                checkOutput("w2_product", 32'(w2_product), 32'(ai * bi));
                @(posedge clk);
                #1;
                checkOutput("w2_in_ready", 32'(w2_in_ready), 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
